// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator arithmetic stage.
package calc_pkg;

    localparam int unsigned W           = 10;
    localparam int unsigned RW          = 20;
    localparam int unsigned DIGITS      = 6;
    localparam int unsigned MAX_OPERAND = 999;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CHECK  = 3'd1,
        S_ADDSUB = 3'd2,
        S_MUL    = 3'd3,
        S_DIV    = 3'd4,
        S_BCD    = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    typedef struct packed {
        logic [1:0]   op;
        logic         sig1;
        logic         sig2;
        logic [W-1:0] num1;
        logic [W-1:0] num2;
    } calc_req_t;

    // One double-dabble step: add-3 on every digit >= 5, then shift in bit_in.
    function automatic logic [4*DIGITS-1:0] dd_step(input logic [4*DIGITS-1:0] cur,
                                                    input logic                bit_in);
        logic [4*DIGITS-1:0] adj;
        adj = cur;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
        end
        return {adj[4*DIGITS-2:0], bit_in};
    endfunction

endpackage

// File: rtl/calc_engine_if.sv
// Request/result bundle between the keypad converter and the arithmetic stage.
interface calc_engine_if;
    import calc_pkg::*;

    logic                start;
    logic [W-1:0]        num1;
    logic [W-1:0]        num2;
    logic                sig1;
    logic                sig2;
    logic [1:0]          op;
    logic                busy;
    logic                done;
    logic                res_sign;
    logic [RW-1:0]       res_mag;
    logic [4*DIGITS-1:0] res_bcd;
    logic                err;

    modport master (output start, num1, num2, sig1, sig2, op,
                    input  busy, done, res_sign, res_mag, res_bcd, err);

    modport slave  (input  start, num1, num2, sig1, sig2, op,
                    output busy, done, res_sign, res_mag, res_bcd, err);
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: the start edge performs the first shift, so the
// last of RW shifts lands RW-1 edges later and done is seen RW edges after start.
module bin2bcd_seq
    import calc_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [RW-1:0]       bin,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] bcd
);
    localparam int unsigned CNT_W = $clog2(RW);

    logic [RW-1:0]    sh_q;
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_q  <= '0;
            cnt_q <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            bcd   <= '0;
        end else begin
            done <= 1'b0;
            if (start && !busy) begin
                bcd   <= dd_step('0, bin[RW-1]);
                sh_q  <= bin << 1;
                cnt_q <= CNT_W'(1);
                busy  <= 1'b1;
            end else if (busy) begin
                bcd   <= dd_step(bcd, sh_q[RW-1]);
                sh_q  <= sh_q << 1;
                cnt_q <= cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(RW-1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/calc_engine.sv
// Sign-magnitude add/sub/mul/div on 3-digit operands with sequential
// mul/div and a BCD image of the result for the display path.
module calc_engine
    import calc_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    calc_engine_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(W);

    state_t           state, state_nxt;
    calc_req_t        req_q;
    logic [RW-1:0]    acc_q, mcand_q, mag_q;
    logic [W-1:0]     shr_q, rem_q;
    logic [CNT_W-1:0] cnt_q;
    logic             sign_q;

    logic                operand_bad_c, launch_c, last_step_c, sig2_eff_c;
    logic [W:0]          sum_c, trial_c;
    logic                fits_c;
    logic [W-1:0]        quo_step_c, rem_step_c;
    logic [RW-1:0]       acc_step_c, addsub_mag_c, mag_c;
    logic                addsub_sign_c, sign_c;
    logic                cvt_busy, cvt_done;
    logic [4*DIGITS-1:0] cvt_bcd;

    // Arithmetic step logic; the final mul/div step feeds the converter directly.
    always_comb begin
        operand_bad_c = (req_q.num1 > W'(MAX_OPERAND)) || (req_q.num2 > W'(MAX_OPERAND)) ||
                        ((req_q.op == OP_DIV) && (req_q.num2 == '0));
        last_step_c   = (cnt_q == CNT_W'(W-1));
        sig2_eff_c    = req_q.sig2 ^ (req_q.op == OP_SUB);
        sum_c         = {1'b0, req_q.num1} + {1'b0, req_q.num2};
        addsub_mag_c  = RW'(sum_c);
        addsub_sign_c = req_q.sig1;
        if (req_q.sig1 != sig2_eff_c) begin
            if (req_q.num1 >= req_q.num2) begin
                addsub_mag_c = RW'(req_q.num1 - req_q.num2);
            end else begin
                addsub_mag_c  = RW'(req_q.num2 - req_q.num1);
                addsub_sign_c = sig2_eff_c;
            end
        end

        acc_step_c = acc_q + (shr_q[0] ? mcand_q : '0);
        trial_c    = {rem_q, shr_q[W-1]};
        fits_c     = (trial_c >= {1'b0, req_q.num2});
        rem_step_c = fits_c ? W'(trial_c - {1'b0, req_q.num2}) : trial_c[W-1:0];
        quo_step_c = {shr_q[W-2:0], fits_c};

        mag_c  = '0;
        sign_c = req_q.sig1 ^ req_q.sig2;
        case (state)
            S_ADDSUB: begin
                mag_c  = addsub_mag_c;
                sign_c = addsub_sign_c;
            end
            S_MUL:   mag_c = acc_step_c;
            S_DIV:   mag_c = RW'(quo_step_c);
            default: mag_c = '0;
        endcase
        if (mag_c == '0) sign_c = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        launch_c  = 1'b0;
        case (state)
            S_IDLE: if (bus.start) state_nxt = S_CHECK;
            S_CHECK: begin
                if (operand_bad_c)             state_nxt = S_DONE;
                else if (req_q.op == OP_MUL)   state_nxt = S_MUL;
                else if (req_q.op == OP_DIV)   state_nxt = S_DIV;
                else                           state_nxt = S_ADDSUB;
            end
            S_ADDSUB: begin
                launch_c  = 1'b1;
                state_nxt = S_BCD;
            end
            S_MUL, S_DIV: begin
                if (last_step_c) begin
                    launch_c  = 1'b1;
                    state_nxt = S_BCD;
                end
            end
            S_BCD:   if (cvt_done && !cvt_busy) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_q        <= '0;
            acc_q        <= '0;
            mcand_q      <= '0;
            shr_q        <= '0;
            rem_q        <= '0;
            cnt_q        <= '0;
            mag_q        <= '0;
            sign_q       <= 1'b0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.res_sign <= 1'b0;
            bus.res_mag  <= '0;
            bus.res_bcd  <= '0;
            bus.err      <= 1'b0;
        end else begin
            bus.busy <= (state_nxt != S_IDLE);
            bus.done <= (state_nxt == S_DONE);
            case (state)
                S_IDLE: begin
                    if (bus.start) req_q <= {bus.op, bus.sig1, bus.sig2, bus.num1, bus.num2};
                end
                S_CHECK: begin
                    cnt_q   <= '0;
                    acc_q   <= '0;
                    rem_q   <= '0;
                    mcand_q <= RW'(req_q.num1);
                    shr_q   <= (req_q.op == OP_DIV) ? req_q.num1 : req_q.num2;
                    if (operand_bad_c) begin
                        bus.err      <= 1'b1;
                        bus.res_sign <= 1'b0;
                        bus.res_mag  <= '0;
                        bus.res_bcd  <= '0;
                    end
                end
                S_MUL: begin
                    acc_q   <= acc_step_c;
                    mcand_q <= mcand_q << 1;
                    shr_q   <= shr_q >> 1;
                    cnt_q   <= cnt_q + CNT_W'(1);
                end
                S_DIV: begin
                    rem_q <= rem_step_c;
                    shr_q <= quo_step_c;
                    cnt_q <= cnt_q + CNT_W'(1);
                end
                S_BCD: begin
                    if (state_nxt == S_DONE) begin
                        bus.err      <= 1'b0;
                        bus.res_sign <= sign_q;
                        bus.res_mag  <= mag_q;
                        bus.res_bcd  <= cvt_bcd;
                    end
                end
                default: ;
            endcase
            if (launch_c) begin
                mag_q  <= mag_c;
                sign_q <= sign_c;
            end
        end
    end

    bin2bcd_seq u_bin2bcd (
        .clk   (clk),
        .rst   (rst),
        .start (launch_c),
        .bin   (mag_c),
        .busy  (cvt_busy),
        .done  (cvt_done),
        .bcd   (cvt_bcd)
    );

endmodule

// File: tb/tb_calc_engine.sv
// Directed-vector bench for calc_engine: results, latency, handshake and reset.
module tb_calc_engine;
    import calc_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   n_vec  = 0;
    int   n_miss = 0;

    always #5 clk = ~clk;

    calc_engine_if bus ();

    calc_engine dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] op,
                          input logic s1, input int unsigned n1,
                          input logic s2, input int unsigned n2,
                          input logic es, input int unsigned emag, input logic [23:0] ebcd,
                          input logic eerr, input int unsigned elat, input bit poke);
        int  k;
        int  busy_low;
        int  extra;
        bit  seen;
        @(negedge clk);
        bus.op    = op;
        bus.sig1  = s1;
        bus.num1  = W'(n1);
        bus.sig2  = s2;
        bus.num2  = W'(n2);
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        chk({tag, "_busy_rise"}, 32'(bus.busy), 32'd1);
        k = 0; busy_low = 0; seen = 1'b0;
        while (!seen && k < 100) begin
            @(posedge clk);
            #1 k++;
            if (!bus.busy) busy_low++;
            if (bus.done) seen = 1'b1;
            if (poke && k == 5) begin
                bus.start = 1'b1;
                bus.num1  = W'(3);
            end
            if (poke && k == 6) bus.start = 1'b0;
        end
        if (!seen) begin
            chk({tag, "_timeout"}, 32'd0, 32'd1);
            return;
        end
        chk({tag, "_busy_hold"}, 32'(busy_low), 32'd0);
        chk({tag, "_latency"},   32'(k + 1),    32'(elat));
        chk({tag, "_mag"},       32'(bus.res_mag),  32'(emag));
        chk({tag, "_sign"},      32'(bus.res_sign), 32'(es));
        chk({tag, "_bcd"},       32'(bus.res_bcd),  32'(ebcd));
        chk({tag, "_err"},       32'(bus.err),      32'(eerr));
        if (poke) bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        chk({tag, "_done_pulse"}, 32'(bus.done),    32'd0);
        chk({tag, "_busy_fall"},  32'(bus.busy),    32'd0);
        chk({tag, "_mag_held"},   32'(bus.res_mag), 32'(emag));
        if (poke) begin
            extra = 0;
            repeat (40) begin
                @(posedge clk);
                #1 if (bus.done) extra++;
            end
            chk({tag, "_extra_done"}, 32'(extra), 32'd0);
        end
    endtask

    initial begin
        int extra;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.op    = OP_ADD;
        bus.sig1  = 1'b0;
        bus.sig2  = 1'b0;
        bus.num1  = '0;
        bus.num2  = '0;
        @(negedge clk);
        chk("rst_busy", 32'(bus.busy),     32'd0);
        chk("rst_done", 32'(bus.done),     32'd0);
        chk("rst_mag",  32'(bus.res_mag),  32'd0);
        chk("rst_bcd",  32'(bus.res_bcd),  32'd0);
        chk("rst_err",  32'(bus.err),      32'd0);
        chk("rst_sign", 32'(bus.res_sign), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        //      tag        op      s1  n1    s2  n2   es  mag     bcd          err lat poke
        run_op("add",      OP_ADD, 0, 123,  0, 456,  0, 579,    24'h000579, 0, 23, 0);
        run_op("sub",      OP_SUB, 0, 5,    0, 12,   1, 7,      24'h000007, 0, 23, 0);
        run_op("add_zero", OP_ADD, 0, 7,    1, 7,    0, 0,      24'h000000, 0, 23, 0);
        run_op("sub_neg",  OP_SUB, 1, 300,  1, 800,  0, 500,    24'h000500, 0, 23, 0);
        run_op("mul_max",  OP_MUL, 1, 999,  0, 999,  1, 998001, 24'h998001, 0, 32, 0);
        run_op("mul_zero", OP_MUL, 0, 0,    1, 5,    0, 0,      24'h000000, 0, 32, 0);
        run_op("div",      OP_DIV, 0, 100,  1, 7,    1, 14,     24'h000014, 0, 32, 0);
        run_op("div_zero", OP_DIV, 0, 5,    0, 0,    0, 0,      24'h000000, 1, 2,  0);
        run_op("err_clr",  OP_ADD, 0, 1,    0, 2,    0, 3,      24'h000003, 0, 23, 0);
        run_op("big_opnd", OP_ADD, 0, 1000, 0, 1,    0, 0,      24'h000000, 1, 2,  0);
        run_op("mul_poke", OP_MUL, 0, 123,  0, 45,   0, 5535,   24'h005535, 0, 32, 1);
        run_op("div_neg",  OP_DIV, 1, 999,  1, 1,    0, 999,    24'h000999, 0, 32, 0);

        // Reset in the middle of a multiply.
        @(negedge clk);
        bus.op = OP_MUL; bus.sig1 = 1'b0; bus.num1 = W'(12); bus.sig2 = 1'b0; bus.num2 = W'(34);
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (7) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_busy", 32'(bus.busy),     32'd0);
        chk("midrst_done", 32'(bus.done),     32'd0);
        chk("midrst_mag",  32'(bus.res_mag),  32'd0);
        chk("midrst_bcd",  32'(bus.res_bcd),  32'd0);
        chk("midrst_sign", 32'(bus.res_sign), 32'd0);
        chk("midrst_err",  32'(bus.err),      32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        extra = 0;
        repeat (40) begin
            @(posedge clk);
            #1 if (bus.done) extra++;
        end
        chk("midrst_no_done", 32'(extra), 32'd0);
        run_op("post_rst", OP_SUB, 0, 0,    0, 250,  1, 250,    24'h000250, 0, 23, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule
